// File: rtl/apb_ram_arbiter_if.sv
// APB master/slave signal bundle between apb_ram_arbiter and the apb_ram slave.
interface apb_ram_arbiter_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_ram_arbiter.sv
// Two-requester round-robin arbiter sequencing single-word APB transfers to apb_ram.
// Optional ACCESS-phase timeout is built when APB_ARB_TIMEOUT_EN is defined.
module apb_ram_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,
  apb_ram_arbiter_if.master apb
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic        ready0_q, ready0_d, ready1_q, ready1_d;
  logic        rv0_q, rv0_d, rv1_q, rv1_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic        sel0;
  logic        done;
  logic [31:0] fin_rdata;
  logic        fin_err;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ready0_q  <= 1'b0;
      ready1_q  <= 1'b0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ready0_q  <= ready0_d;
      ready1_q  <= ready1_d;
      rv0_q     <= rv0_d;
      rv1_q     <= rv1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // requester 0 wins when alone, or when contested and requester 1 was served last
  assign sel0 = req0_valid && (!req1_valid || last_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    ready0_d  = 1'b0;
    ready1_d  = 1'b0;
    rv0_d     = 1'b0;
    rv1_d     = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    done      = 1'b0;
    fin_rdata = '0;
    fin_err   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (req0_valid || req1_valid) begin
          gnt_d    = !sel0;
          pwrite_d = sel0 ? req0_write : req1_write;
          paddr_d  = sel0 ? req0_addr  : req1_addr;
          pwdata_d = sel0 ? req0_wdata : req1_wdata;
          ready0_d = sel0;
          ready1_d = !sel0;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (apb.pready) begin
          done      = 1'b1;
          fin_rdata = pwrite_q ? 32'h0 : apb.prdata;
          fin_err   = apb.pslverr;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          done    = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        psel_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      last_d    = gnt_q;
      state_d   = RESP;
      if (gnt_q) begin
        rv1_d    = 1'b1;
        rdata1_d = fin_rdata;
        err1_d   = fin_err;
      end else begin
        rv0_d    = 1'b1;
        rdata0_d = fin_rdata;
        err0_d   = fin_err;
      end
    end
  end

  assign req0_ready  = ready0_q;
  assign req1_ready  = ready1_q;
  assign resp0_valid = rv0_q;
  assign resp1_valid = rv1_q;
  assign resp0_rdata = rdata0_q;
  assign resp1_rdata = rdata1_q;
  assign resp0_err   = err0_q;
  assign resp1_err   = err1_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

endmodule
